// File: rtl/icap_7series_pkg.sv
// 7-series configuration packet constants, register map, reader FSM states and
// the small helpers shared by the ICAP readback engine.
package icap_7series_pkg;

    localparam logic [31:0] SYNC_WORD  = 32'haa995566;
    localparam logic [31:0] NOP_WORD   = 32'h20000000;
    localparam logic [31:0] DUMMY_WORD = 32'hffffffff;
    localparam logic [31:0] CMD_DESYNC = 32'h0000000d;

    localparam logic [2:0] T1_TYPE  = 3'b001;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    typedef enum logic [4:0] {
        REG_CRC     = 5'h00,
        REG_FAR     = 5'h01,
        REG_FDRI    = 5'h02,
        REG_FDRO    = 5'h03,
        REG_CMD     = 5'h04,
        REG_CTL0    = 5'h05,
        REG_MASK    = 5'h06,
        REG_STAT    = 5'h07,
        REG_LOUT    = 5'h08,
        REG_COR0    = 5'h09,
        REG_MFWR    = 5'h0a,
        REG_CBC     = 5'h0b,
        REG_IDCODE  = 5'h0c,
        REG_AXSS    = 5'h0d,
        REG_COR1    = 5'h0e,
        REG_WBSTAR  = 5'h10,
        REG_TIMER   = 5'h11,
        REG_BOOTSTS = 5'h16,
        REG_CTL1    = 5'h18,
        REG_BSPI    = 5'h1f
    } cfg_reg_e;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_SYNC,
        ST_NOP,
        ST_HEADER,
        ST_PIPE,
        ST_READ,
        ST_DESYNC,
        ST_IDLE
    } rd_state_e;

    typedef struct packed {
        logic        csib;
        logic        rdwrb;
        logic [31:0] word;
    } icap_ctl_t;

    // Type-1 packet: type, opcode, 14-bit address field (5 bits used), reserved, word count.
    function automatic logic [31:0] t1_header(input logic [1:0] op, input logic [4:0] addr,
                                              input logic [10:0] wc);
        return {T1_TYPE, op, 9'd0, addr, 2'd0, wc};
    endfunction

    // ICAPE2 data pins carry each byte MSB/LSB-reversed.
    function automatic logic [31:0] bitswap32(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) begin
                r[8*b+k] = w[8*b+7-k];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dna_reader_7series.sv
// DNA_PORT sequencer: one READ pulse, then 57 SHIFT cycles collecting DOUT into [63:7].
// Compiled only when ICAP_REG_READER_DNA_EN is defined.
`ifdef ICAP_REG_READER_DNA_EN
module dna_reader_7series (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dna_dout,
    output logic        dna_read,
    output logic        dna_shift,
    output logic [63:0] serial,
    output logic        serial_valid
);

    logic        read_q, read_d;
    logic        shift_q, shift_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [56:0] dna_q, dna_d;
    logic        valid_q, valid_d;

    always_comb begin
        read_d  = start;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        dna_d   = dna_q;
        valid_d = valid_q;
        if (read_q) begin
            shift_d = 1'b1;
            cnt_d   = 6'd0;
        end
        // First bit out lands at the bottom of the 57-bit field after all shifts.
        if (shift_q) begin
            dna_d = {dna_dout, dna_q[56:1]};
            if (cnt_q == 6'd56) begin
                shift_d = 1'b0;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_q  <= 1'b0;
            shift_q <= 1'b0;
            cnt_q   <= 6'd0;
            dna_q   <= 57'd0;
            valid_q <= 1'b0;
        end else begin
            read_q  <= read_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            dna_q   <= dna_d;
            valid_q <= valid_d;
        end
    end

    assign dna_read     = read_q;
    assign dna_shift    = shift_q;
    assign serial       = {dna_q, 7'd0};
    assign serial_valid = valid_q;

endmodule
`endif

// File: rtl/icap_reg_reader_7series.sv
// Single-word type-1 register reader over ICAPE2 with boot-time IDCODE read; the ICAPE2 and
// DNA_PORT primitives sit in the wrapper. Optional DNA capture: define ICAP_REG_READER_DNA_EN.
module icap_reg_reader_7series #(
    parameter logic [23:0] BOOT_CYCLES = 24'hffffff,
    parameter logic [3:0]  READ_SAMPLE = 4'd3,
    parameter logic [4:0]  IDCODE_ADDR = 5'h0c
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_addr,
    output logic        rsp_valid,
    output logic [4:0]  rsp_addr,
    output logic [31:0] rsp_data,
    output logic [31:0] idcode,
    output logic        idcode_valid,
    output logic [63:0] die_serial,
    output logic        die_serial_valid,
    output logic        icap_csib,
    output logic        icap_rdwrb,
    output logic [31:0] icap_i,
    input  logic [31:0] icap_o,
    output logic        dna_read,
    output logic        dna_shift,
    input  logic        dna_dout
);

    import icap_7series_pkg::*;

    rd_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [23:0] boot_cnt_q, boot_cnt_d;
    logic [4:0]  addr_q, addr_d;
    logic        boot_rd_q, boot_rd_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [4:0]  rsp_addr_q, rsp_addr_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [31:0] idcode_q, idcode_d;
    logic        idcode_valid_q, idcode_valid_d;
    icap_ctl_t   ctl_q, ctl_d;
    logic        dna_start;

    // ICAP pin values for the cycle spent in state st at count c.
    function automatic icap_ctl_t icap_ctl(input rd_state_e st, input logic [3:0] c,
                                           input logic [4:0] a);
        icap_ctl_t r;
        r.csib  = 1'b1;
        r.rdwrb = 1'b1;
        r.word  = DUMMY_WORD;
        case (st)
            ST_SYNC: begin
                r.csib  = 1'b0;
                r.rdwrb = 1'b0;
                r.word  = SYNC_WORD;
            end
            ST_NOP: begin
                r.csib  = 1'b0;
                r.rdwrb = 1'b0;
                r.word  = NOP_WORD;
            end
            ST_HEADER: begin
                r.csib  = 1'b0;
                r.rdwrb = 1'b0;
                r.word  = t1_header(OP_READ, a, 11'd1);
            end
            // Deselect before flipping direction, then reselect for the read.
            ST_PIPE: begin
                r.csib  = (c == 4'd2) || (c == 4'd3);
                r.rdwrb = (c >= 4'd3);
                r.word  = NOP_WORD;
            end
            ST_READ: begin
                r.csib  = 1'b0;
                r.rdwrb = 1'b1;
                r.word  = NOP_WORD;
            end
            ST_DESYNC: begin
                r.csib  = (c == 4'd0) || (c == 4'd1) || (c == 4'd8);
                r.rdwrb = (c == 4'd0);
                if (c == 4'd4) begin
                    r.word = t1_header(OP_WRITE, REG_CMD, 11'd1);
                end else if (c == 4'd5) begin
                    r.word = CMD_DESYNC;
                end else begin
                    r.word = NOP_WORD;
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        boot_cnt_d     = boot_cnt_q;
        addr_d         = addr_q;
        boot_rd_d      = boot_rd_q;
        rsp_valid_d    = 1'b0;
        rsp_addr_d     = rsp_addr_q;
        rsp_data_d     = rsp_data_q;
        idcode_d       = idcode_q;
        idcode_valid_d = idcode_valid_q;
        dna_start      = 1'b0;

        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == BOOT_CYCLES) begin
                    state_d   = ST_SYNC;
                    addr_d    = IDCODE_ADDR;
                    boot_rd_d = 1'b1;
                    dna_start = 1'b1;
                end else begin
                    boot_cnt_d = boot_cnt_q + 24'd1;
                end
            end
            ST_SYNC: begin
                state_d = ST_NOP;
                cnt_d   = 4'd0;
            end
            ST_NOP: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_HEADER;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HEADER: begin
                state_d = ST_PIPE;
                cnt_d   = 4'd0;
            end
            ST_PIPE: begin
                if (cnt_q == 4'd4) begin
                    state_d = ST_READ;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_READ: begin
                // The boot read only feeds idcode; fabric never sees it as a response.
                if (cnt_q == READ_SAMPLE) begin
                    if (boot_rd_q) begin
                        idcode_d       = bitswap32(icap_o);
                        idcode_valid_d = 1'b1;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_addr_d  = addr_q;
                        rsp_data_d  = bitswap32(icap_o);
                    end
                end
                if (cnt_q == 4'd8) begin
                    state_d = ST_DESYNC;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DESYNC: begin
                if (cnt_q == 4'd8) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_IDLE: begin
                if (req_valid) begin
                    state_d   = ST_SYNC;
                    addr_d    = req_addr;
                    boot_rd_d = 1'b0;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        req_ready_d = (state_d == ST_IDLE);
        ctl_d       = icap_ctl(state_d, cnt_d, addr_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_BOOT;
            cnt_q          <= 4'd0;
            boot_cnt_q     <= 24'd0;
            addr_q         <= 5'd0;
            boot_rd_q      <= 1'b0;
            req_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_addr_q     <= 5'd0;
            rsp_data_q     <= 32'd0;
            idcode_q       <= 32'd0;
            idcode_valid_q <= 1'b0;
            ctl_q          <= '{csib: 1'b1, rdwrb: 1'b1, word: DUMMY_WORD};
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            boot_cnt_q     <= boot_cnt_d;
            addr_q         <= addr_d;
            boot_rd_q      <= boot_rd_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_addr_q     <= rsp_addr_d;
            rsp_data_q     <= rsp_data_d;
            idcode_q       <= idcode_d;
            idcode_valid_q <= idcode_valid_d;
            ctl_q          <= ctl_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_addr     = rsp_addr_q;
    assign rsp_data     = rsp_data_q;
    assign idcode       = idcode_q;
    assign idcode_valid = idcode_valid_q;
    assign icap_csib    = ctl_q.csib;
    assign icap_rdwrb   = ctl_q.rdwrb;
    assign icap_i       = bitswap32(ctl_q.word);

`ifdef ICAP_REG_READER_DNA_EN
    dna_reader_7series u_dna (
        .clk          (clk),
        .rst          (rst),
        .start        (dna_start),
        .dna_dout     (dna_dout),
        .dna_read     (dna_read),
        .dna_shift    (dna_shift),
        .serial       (die_serial),
        .serial_valid (die_serial_valid)
    );
`else
    logic unused_dna;
    assign unused_dna       = dna_start ^ dna_dout;
    assign dna_read         = 1'b0;
    assign dna_shift        = 1'b0;
    assign die_serial       = 64'd0;
    assign die_serial_valid = 1'b0;
`endif

endmodule
